// File: rtl/pixel_write_queue.sv
// pixel_write_queue: buffers MCU pixel writes, issues them in order to the memory manager write port.
// Latency: push into an empty idle queue at edge N -> memoryWriteRequest high after edge N+1; >= 3 cycles per write.
// Backpressure: pushReady = !full with no same-cycle bypass; off-screen pushes are accepted, counted and discarded.
// Optional: define PIXEL_QUEUE_COALESCE_EN to merge a same-coordinate push into the newest queued (not in-flight) entry.
module pixel_write_queue #(
    parameter int DEPTH   = 16,
    parameter int X_LIMIT = 320,
    parameter int Y_LIMIT = 240
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pushValid,
    output logic                   pushReady,
    input  logic [8:0]             pushX,
    input  logic [7:0]             pushY,
    input  logic [7:0]             pushData,
    output logic [8:0]             memoryXCoord,
    output logic [7:0]             memoryYCoord,
    output logic [7:0]             memoryWriteData,
    output logic                   memoryWriteRequest,
    input  logic                   memoryWriteComplete,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [7:0]             droppedCount,
    output logic                   busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_RELEASE} state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] data;
    } pixel_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [7:0]         drop_q, drop_d;
    pixel_t             head_q, head_d;
    pixel_t             mem_q [DEPTH];

    logic               push_fire;
    logic               off_screen;
    logic               coalesce;
    logic               store;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic               pop;
`ifdef PIXEL_QUEUE_COALESCE_EN
    logic [PTR_W-1:0]   last_idx;
`endif

    assign pushReady          = (occ_q != OCC_FULL);
    assign busy               = (occ_q != '0);
    assign occupancy          = occ_q;
    assign droppedCount       = drop_q;
    assign memoryWriteRequest = (state_q == S_REQUEST);
    assign memoryXCoord       = head_q.x;
    assign memoryYCoord       = head_q.y;
    assign memoryWriteData    = head_q.data;

    // Push classification, pointer/occupancy bookkeeping and drop counter.
    always_comb begin
        push_fire  = pushValid && pushReady;
        off_screen = (int'(pushX) >= X_LIMIT) || (int'(pushY) >= Y_LIMIT);
`ifdef PIXEL_QUEUE_COALESCE_EN
        // With two or more entries the newest one is never the in-flight (or about to launch) head.
        last_idx = wr_ptr_q - PTR_ONE;
        coalesce = (occ_q > OCC_ONE) && (mem_q[last_idx].x == pushX) && (mem_q[last_idx].y == pushY);
`else
        coalesce = 1'b0;
`endif
        wr_en  = push_fire && !off_screen;
        store  = wr_en && !coalesce;
`ifdef PIXEL_QUEUE_COALESCE_EN
        wr_idx = coalesce ? last_idx : wr_ptr_q;
`else
        wr_idx = wr_ptr_q;
`endif
        pop    = (state_q == S_REQUEST) && memoryWriteComplete;

        wr_ptr_d = store ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        occ_d = occ_q;
        if (store && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!store && pop) begin
            occ_d = occ_q - OCC_ONE;
        end

        drop_d = drop_q;
        if (push_fire && off_screen && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Request FSM: launch head from IDLE, hold in REQUEST until complete, one dead cycle in RELEASE.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        case (state_q)
            S_IDLE: begin
                if (occ_q != '0) begin
                    head_d  = mem_q[rd_ptr_q];
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (memoryWriteComplete) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control state with asynchronous reset; reset abandons any in-flight request and queued entries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
        end
    end

    // Queue storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= '{x: pushX, y: pushY, data: pushData};
        end
    end

endmodule
